// File: rtl/mul_seq_pkg.sv
// ============================================================================
// Module : mul_seq_pkg
// Purpose: Shared constants and the FSM state type for the sequential
//          shift-and-add multiplier (mul_seq) and its adder (add).
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_seq_pkg;

  // Operand / product width; the datapath is built around a 32-bit adder.
  localparam int MUL_WIDTH = 32;

  // Step counter width: counts 0..31 for 32 multiplier bits.
  localparam int CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mul_seq_pkg

`default_nettype wire

// File: rtl/mul_seq_add.sv
// ============================================================================
// Module : add
// Purpose: Plain ripple-style 32-bit adder with carry-in and carry-out.
//          The carry-out doubles as the unsigned overflow indication.
// Ports  : a_i, b_i   addends
//          c_in_i     carry in
//          sum_o      low WIDTH bits of a_i + b_i + c_in_i
//          c_out_o    carry out of the top bit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module add
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o
);

  // Zero-extend by one bit so the carry falls out of the top.
  assign {c_out_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_in_i};

endmodule : add

`default_nettype wire

// File: rtl/mul_seq.sv
// ============================================================================
// Module : mul_seq
// Purpose: Sequential unsigned 32x32 multiplier, one multiplier bit per
//          cycle, producing the low 32 product bits and an overflow flag.
// Ports  : clk       rising-edge clock
//          rst_n     synchronous active-low reset
//          start_i   begin a multiply (accepted only while ready_o=1)
//          a_i, b_i  multiplicand / multiplier, sampled on accept
//          ready_o   high in IDLE
//          done_o    one-cycle completion pulse
//          p_o       low 32 bits of the product (held between results)
//          ovf_o     high when the full product does not fit in 32 bits
// Config : MUL_SEQ_EARLY_EN - when defined, finish as soon as the remaining
//          multiplier bits are all zero (results unchanged, fewer cycles).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o,
  output logic             ovf_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIDTH - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       m_q, m_d;       // shifted multiplicand
  logic [WIDTH-1:0]       q_q, q_d;       // remaining multiplier bits
  logic [WIDTH-1:0]       acc_q, acc_d;   // partial product
  logic                   l_q, l_d;       // a set bit of M has shifted out
  logic                   s_q, s_d;       // sticky overflow
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       p_q, p_d;
  logic                   ovf_q, ovf_d;

  logic [WIDTH-1:0]       add_sum;
  logic                   add_carry;
  logic [WIDTH-1:0]       q_shift;
  logic                   last_step;

  add #(.WIDTH(WIDTH)) u_add (
    .a_i     (acc_q),
    .b_i     (m_q),
    .c_in_i  (1'b0),
    .sum_o   (add_sum),
    .c_out_o (add_carry)
  );

  assign q_shift = q_q >> 1;

`ifdef MUL_SEQ_EARLY_EN
  // Once no multiplier bits remain, further steps cannot change ACC or S.
  assign last_step = (cnt_q == CNT_LAST) || (q_shift == '0);
`else
  assign last_step = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    l_d     = l_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          m_d     = a_i;
          q_d     = b_i;
          acc_d   = '0;
          l_d     = 1'b0;
          s_d     = 1'b0;
          cnt_d   = '0;
        end
      end

      RUN: begin
        if (q_q[0]) begin
          acc_d = add_sum;
          // A lost M bit only matters once a later partial product would
          // have included it, so L folds into S on an add step.
          s_d   = s_q | add_carry | l_q;
        end
        q_d   = q_shift;
        m_d   = m_q << 1;
        l_d   = l_q | m_q[WIDTH-1];
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d = DONE;
          p_d     = acc_d;
          ovf_d   = s_d;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      l_q     <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      l_q     <= l_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = (state_q == DONE);
  assign p_o     = p_q;
  assign ovf_o   = ovf_q;

endmodule : mul_seq

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
// Module : tb_mul_seq
// Purpose: Self-checking bench for mul_seq. Expected products are computed
//          with a 64-bit multiply and queued on accept, then popped when
//          done_o is seen. Step counts follow MUL_SEQ_EARLY_EN if defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

  typedef struct {
    logic [31:0] p;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] p_o;
  logic        ovf_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .ready_o (ready_o),
    .done_o  (done_o),
    .p_o     (p_o),
    .ovf_o   (ovf_o)
  );

  function automatic int exp_steps(input logic [31:0] b);
    int n;
`ifdef MUL_SEQ_EARLY_EN
    n = 1;
    for (int k = 0; k < 32; k++) if (b[k]) n = k + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    exp_t e;
    full = {32'd0, a} * {32'd0, b};
    e.p  = full[31:0];
    e.o  = (full[63:32] != 32'd0);
    return e;
  endfunction

  // Runs one multiply; all sampling and driving happens 1 time unit after
  // a rising edge.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] prev_p;
    logic        prev_o;
    logic        got;
    logic        unstable;
    int          n;
    exp_t        e;
    prev_p   = p_o;
    prev_o   = ovf_o;
    got      = 1'b0;
    unstable = 1'b0;
    n        = 0;
    total++;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL %s ready_before: got=%b want=1", nm, ready_o);
    end
    start_i = 1'b1; a_i = a; b_i = b;
    sbq.push_back(model(a, b));
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    total++;
    if (ready_o !== 1'b0) begin
      bad++; $display("FAIL %s ready_in_run: got=%b want=0", nm, ready_o);
    end
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        got = 1'b1; n = i;
      end else if (p_o !== prev_p || ovf_o !== prev_o) begin
        unstable = 1'b1;
      end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout: no done_o within 100 cycles", nm);
      void'(sbq.pop_front());
      return;
    end
    total++;
    if (unstable) begin
      bad++; $display("FAIL %s result_held: p_o/ovf_o changed during run, want %h/%b", nm, prev_p, prev_o);
    end
    total++;
    if (n != exp_steps(b)) begin
      bad++; $display("FAIL %s latency: got=%0d want=%0d", nm, n, exp_steps(b));
    end
    e = sbq.pop_front();
    total++;
    if (p_o !== e.p) begin
      bad++; $display("FAIL %s p_o: got=%h want=%h", nm, p_o, e.p);
    end
    total++;
    if (ovf_o !== e.o) begin
      bad++; $display("FAIL %s ovf_o: got=%b want=%b", nm, ovf_o, e.o);
    end
    @(posedge clk); #1;
    total++;
    if (done_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL %s after_done: done=%b ready=%b want done=0 ready=1", nm, done_o, ready_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b1 || done_o !== 1'b0 || p_o !== 32'd0 || ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b done=%b p=%h ovf=%b want 1 0 0 0", ready_o, done_o, p_o, ovf_o);
    end
    start_i = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_idle: ready=%b want 1", ready_o);
    end
  endtask

  task automatic test_vectors();
    do_mul(32'd3,        32'd5,        "basic_3x5");
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, "max_x_max");
    do_mul(32'h00010000, 32'h00010000, "lost_bit");
    do_mul(32'h0000FFFF, 32'h00010001, "fits_exact");
    do_mul(32'h00001234, 32'h00000000, "b_zero");
    do_mul(32'h00000001, 32'h80000000, "b_msb");
    do_mul(32'h00000000, 32'hFFFFFFFF, "a_zero");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      do_mul($urandom, $urandom_range(0, 65535), "random");
    end
  endtask

  task automatic test_ignore_start();
    int   steps;
    int   p1;
    int   p2;
    int   n;
    exp_t e;
    steps = exp_steps(32'd6);
    p1    = (steps > 5) ? 5 : 1;
    p2    = steps + 1;
    n     = 0;
    start_i = 1'b1; a_i = 32'd7; b_i = 32'd6;
    sbq.push_back(model(32'd7, 32'd6));
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 1; i <= steps + 2; i++) begin
      start_i = (i == p1 || i == p2);
      a_i = 32'd3; b_i = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_o === 1'b1 && n == 0) n = i;
      if (i == steps + 1) begin
        total++;
        if (ready_o !== 1'b1) begin
          bad++; $display("FAIL ignore_ready_back: ready=%b want 1", ready_o);
        end
      end
    end
    total++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL ignore_no_queue: ready=%b done=%b want 1 0", ready_o, done_o);
    end
    total++;
    if (n != steps) begin
      bad++; $display("FAIL ignore_latency: got=%0d want=%0d", n, steps);
    end
    e = sbq.pop_front();
    total++;
    if (p_o !== e.p || ovf_o !== e.o) begin
      bad++; $display("FAIL ignore_result: p=%h ovf=%b want %h %b", p_o, ovf_o, e.p, e.o);
    end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    saw_done = 1'b0;
    start_i = 1'b1; a_i = 32'd9; b_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (ready_o !== 1'b1 || done_o !== 1'b0 || p_o !== 32'd0 || ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: ready=%b done=%b p=%h ovf=%b want 1 0 0 0", ready_o, done_o, p_o, ovf_o);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++; $display("FAIL abort_no_done: done_o pulsed, want none");
    end
    do_mul(32'd3, 32'd5, "after_abort");
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL scoreboard_empty: %0d left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mul_seq

`default_nettype wire
